// File: rtl/wm_embed_seq_pkg.sv
// wm_embed_seq_pkg: package wm_pkg with the sequencer state enum, default pixel width and the LSB-embed helper
package wm_pkg;
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_e;
  localparam int DW_DEF = 8;
  localparam int DW_MAX = 32;
  function automatic logic [DW_MAX-1:0] embed_lsb(input logic [DW_MAX-1:0] im, input logic [DW_MAX-1:0] wm, input int dw);
    return {im[DW_MAX-1:1], wm[dw-1]};
  endfunction
endpackage

// File: rtl/wm_embed_seq_if.sv
// wm_embed_seq_if: host handshake (start/abort/ready/busy/done) plus image and watermark memory ports; master=sequencer, slave=host+memories
interface wm_embed_seq_if import wm_pkg::*; #(
  parameter int RW = 6,
  parameter int CW = 6,
  parameter int DW = DW_DEF
);
  logic          start, abort, ready, busy, done;
  logic          im_en, im_rd_wrn, wm_en, wm_rd_wrn;
  logic [RW-1:0] im_row, wm_row;
  logic [CW-1:0] im_col, wm_col;
  logic [DW-1:0] im_wdata, im_rdata, wm_rdata;
  modport master (
    input  start, abort, im_rdata, wm_rdata,
    output ready, busy, done, im_en, im_rd_wrn, im_row, im_col, im_wdata,
           wm_en, wm_rd_wrn, wm_row, wm_col
  );
  modport slave (
    output start, abort, im_rdata, wm_rdata,
    input  ready, busy, done, im_en, im_rd_wrn, im_row, im_col, im_wdata,
           wm_en, wm_rd_wrn, wm_row, wm_col
  );
endinterface

// File: rtl/wm_embed_seq_addr_gen.sv
// wm_addr_gen: raster row/col counters (clr_i, adv_i -> row_o, col_o, wm_row_o, wm_col_o, last_pixel_o); WM_TILE_EN adds watermark wrap counters
module wm_addr_gen #(
  parameter int ROWS    = 64,
  parameter int COLS    = 64,
  parameter int RW      = 6,
  parameter int CW      = 6,
  parameter int WM_ROWS = 16,
  parameter int WM_COLS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] wm_row_o,
  output logic [CW-1:0] wm_col_o,
  output logic          last_pixel_o
);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_last, step;
  assign col_last     = col_q == CW'(COLS - 1);
  assign last_pixel_o = col_last && row_q == RW'(ROWS - 1);
  // the final pixel does not advance, so addresses keep pointing at it after the frame
  assign step         = adv_i && !last_pixel_o;
  assign row_o        = row_q;
  assign col_o        = col_q;
  always_comb begin
    row_d = clr_i ? '0 : (step && col_last) ? row_q + 1'b1 : row_q;
    col_d = clr_i ? '0 : step ? (col_last ? '0 : col_q + 1'b1) : col_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
`ifdef WM_TILE_EN
  localparam int WRW = WM_ROWS > 1 ? $clog2(WM_ROWS) : 1;
  localparam int WCW = WM_COLS > 1 ? $clog2(WM_COLS) : 1;
  logic [WRW-1:0] wr_q, wr_d;
  logic [WCW-1:0] wc_q, wc_d;
  // incremental modulo: wrap at the tile edge, and restart the column whenever the image row wraps
  always_comb begin
    wc_d = clr_i ? '0 : step ? ((col_last || wc_q == WCW'(WM_COLS - 1)) ? '0 : wc_q + 1'b1) : wc_q;
    wr_d = clr_i ? '0 : (step && col_last) ? ((wr_q == WRW'(WM_ROWS - 1)) ? '0 : wr_q + 1'b1) : wr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      wc_q <= '0;
    end else begin
      wr_q <= wr_d;
      wc_q <= wc_d;
    end
  end
  assign wm_row_o = RW'(wr_q);
  assign wm_col_o = CW'(wc_q);
`else
  assign wm_row_o = row_q;
  assign wm_col_o = col_q;
`endif
endmodule

// File: rtl/wm_embed_seq.sv
// wm_embed_seq: raster read/embed/write-back sequencer; ports clk, rst and wm_embed_seq_if.master bus; WM_TILE_EN tiles the watermark address
module wm_embed_seq import wm_pkg::*; #(
  parameter int ROWS    = 64,
  parameter int COLS    = 64,
  parameter int RW      = 6,
  parameter int CW      = 6,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 2,
  parameter int WM_ROWS = 16,
  parameter int WM_COLS = 16
) (
  input logic           clk,
  input logic           rst,
  wm_embed_seq_if.master bus
);
  localparam int LW = $clog2(MEM_LAT + 1);
  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] reg_im_q, reg_im_d, reg_wm_q, reg_wm_d;
  logic          last_pixel, idle, active, go;
  assign idle   = state_q == IDLE || state_q == DONE;
  assign active = state_q == RD || state_q == WAIT || state_q == WR;
  // abort beats start when both arrive while idle
  assign go     = idle && bus.start && !bus.abort;
  wm_addr_gen #(
    .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW), .WM_ROWS(WM_ROWS), .WM_COLS(WM_COLS)
  ) u_addr (
    .clk, .rst,
    .clr_i       (go),
    .adv_i       (state_q == WR),
    .row_o       (bus.im_row),
    .col_o       (bus.im_col),
    .wm_row_o    (bus.wm_row),
    .wm_col_o    (bus.wm_col),
    .last_pixel_o(last_pixel)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reg_im_d = reg_im_q;
    reg_wm_d = reg_wm_q;
    unique case (state_q)
      IDLE, DONE: state_d = go ? RD : state_q;
      RD: begin
        state_d = WAIT;
        cnt_d   = LW'(MEM_LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LW'(1)) begin
          state_d  = WR;
          reg_im_d = bus.im_rdata;
          reg_wm_d = bus.wm_rdata;
        end
      end
      WR: state_d = last_pixel ? DONE : RD;
      default: state_d = IDLE;
    endcase
    if (active && bus.abort) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reg_im_q <= '0;
      reg_wm_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reg_im_q <= reg_im_d;
      reg_wm_q <= reg_wm_d;
    end
  end
  assign bus.ready     = idle;
  assign bus.busy      = active;
  assign bus.done      = state_q == DONE;
  assign bus.im_en     = state_q == RD || state_q == WR;
  assign bus.im_rd_wrn = state_q != WR;
  assign bus.wm_en     = state_q == RD;
  assign bus.wm_rd_wrn = 1'b1;
  assign bus.im_wdata  = DW'(embed_lsb(DW_MAX'(reg_im_q), DW_MAX'(reg_wm_q), DW));
endmodule

// File: tb/tb_wm_embed_seq.sv
// tb_wm_embed_seq: directed bench for wm_embed_seq on a 2x3 image with two-cycle memories
module tb_wm_embed_seq;
  localparam int NPIX = 6;
  typedef struct {int cyc; int row; int col; int wrow; int wcol; int data;} ev_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] mem_im [NPIX], mem_wm [NPIX];
  logic [7:0] p1_im, p2_im, p1_wm, p2_wm;
  ev_t wq[$], rq[$];
  wm_embed_seq_if #(.RW(1), .CW(2), .DW(8)) bus ();
  wm_embed_seq #(
    .ROWS(2), .COLS(3), .RW(1), .CW(2), .DW(8), .MEM_LAT(2), .WM_ROWS(1), .WM_COLS(2)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    p1_im <= (bus.im_en && bus.im_rd_wrn) ? mem_im[int'(bus.im_row) * 3 + int'(bus.im_col)] : 8'hxx;
    p1_wm <= bus.wm_en ? mem_wm[int'(bus.wm_row) * 3 + int'(bus.wm_col)] : 8'hxx;
    p2_im <= p1_im;
    p2_wm <= p1_wm;
  end
  assign bus.im_rdata = p2_im;
  assign bus.wm_rdata = p2_wm;
  always @(negedge clk) begin
    if (bus.im_en && !bus.im_rd_wrn)
      wq.push_back('{cyc, int'(bus.im_row), int'(bus.im_col), 0, 0, int'(bus.im_wdata)});
    if (bus.im_en && bus.im_rd_wrn)
      rq.push_back('{cyc, int'(bus.im_row), int'(bus.im_col), int'(bus.wm_row), int'(bus.wm_col), 0});
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_frame(input bit pulse_mid, output int s);
    int n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("done_clr_after_start", bus.done, 0);
    if (pulse_mid) begin
      repeat (5) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_cycle", cyc, s + 24);
  endtask
  task automatic chk_frame(input int s, input logic [7:0] exp_d [NPIX]);
    int er [NPIX] = '{0, 0, 0, 1, 1, 1};
    int ec [NPIX] = '{0, 1, 2, 0, 1, 2};
`ifdef WM_TILE_EN
    int ewr [NPIX] = '{0, 0, 0, 0, 0, 0};
    int ewc [NPIX] = '{0, 1, 0, 0, 1, 0};
`else
    int ewr [NPIX] = '{0, 0, 0, 1, 1, 1};
    int ewc [NPIX] = '{0, 1, 2, 0, 1, 2};
`endif
    ev_t w, r;
    chk("wr_count", wq.size(), NPIX);
    chk("rd_count", rq.size(), NPIX);
    for (int i = 0; i < NPIX; i++) begin
      w = (i < wq.size()) ? wq[i] : '{-1, -1, -1, -1, -1, -1};
      r = (i < rq.size()) ? rq[i] : '{-1, -1, -1, -1, -1, -1};
      chk($sformatf("wr%0d_row", i), w.row, er[i]);
      chk($sformatf("wr%0d_col", i), w.col, ec[i]);
      chk($sformatf("wr%0d_data", i), w.data, exp_d[i]);
      chk($sformatf("wr%0d_cyc", i), w.cyc, s + 4 * i + 3);
      chk($sformatf("rd%0d_cyc", i), r.cyc, s + 4 * i);
      chk($sformatf("rd%0d_addr", i), r.row * 8 + r.col, er[i] * 8 + ec[i]);
      chk($sformatf("rd%0d_wm_addr", i), r.wrow * 8 + r.wcol, ewr[i] * 8 + ewc[i]);
    end
  endtask
  initial begin
    int s;
    logic [7:0] e1 [NPIX] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
    logic [7:0] im2 [NPIX] = '{8'h55, 8'hA2, 8'hFF, 8'h00, 8'h3C, 8'h81};
    logic [7:0] wm2 [NPIX] = '{8'h7F, 8'h80, 8'hFF, 8'h00, 8'hC3, 8'h7F};
`ifdef WM_TILE_EN
    logic [7:0] e2 [NPIX] = '{8'h54, 8'hA3, 8'hFE, 8'h00, 8'h3D, 8'h80};
`else
    logic [7:0] e2 [NPIX] = '{8'h54, 8'hA3, 8'hFF, 8'h00, 8'h3D, 8'h80};
`endif
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      mem_im[i] = 8'h54;
      mem_wm[i] = 8'h80;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_im_en", bus.im_en, 0);
    chk("rst_wm_en", bus.wm_en, 0);
    chk("rst_im_rd_wrn", bus.im_rd_wrn, 1);
    chk("rst_wm_rd_wrn", bus.wm_rd_wrn, 1);
    chk("rst_wdata", bus.im_wdata, 0);
    rst = 1'b0;
    wq.delete();
    rq.delete();
    run_frame(1'b0, s);
    chk("frame1_ready", bus.ready, 1);
    chk_frame(s, e1);
    for (int i = 0; i < NPIX; i++) begin
      mem_im[i] = im2[i];
      mem_wm[i] = wm2[i];
    end
    wq.delete();
    rq.delete();
    chk("done_held", bus.done, 1);
    run_frame(1'b1, s);
    chk_frame(s, e2);
    wq.delete();
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_in_wait", cyc * 2 + int'(bus.im_en), (s + 5) * 2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_ready", bus.ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    repeat (10) @(negedge clk);
    chk("abort_wr_count", wq.size(), 1);
    chk("abort_no_strobe", bus.im_en, 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_ready", bus.ready, 1);
    chk("abort_start_busy", bus.busy, 0);
    for (int i = 0; i < NPIX; i++) begin
      mem_im[i] = 8'h54;
      mem_wm[i] = 8'h80;
    end
    wq.delete();
    rq.delete();
    run_frame(1'b0, s);
    chk_frame(s, e1);
    wq.delete();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_wr_count", wq.size(), 1);
    chk("rst_mid_ready", bus.ready, 1);
    chk("rst_mid_done", bus.done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wm_embed_seq.md
Name: wm_embed_seq

Overview:
- Sequencer for the image-watermarking datapath. After a start command it scans every image pixel in raster order.
- For each pixel it reads the image memory and the watermark memory in parallel, embeds the watermark bit into the image pixel LSB, and writes the result back in place.
- Drives the ready/busy/done status seen by the host and the RD_WRn-style strobes of both single-port pixel memories.

Parameters:
- ROWS, 64, image height in pixels
- COLS, 64, image width in pixels
- RW, 6, row address width (clog2 ROWS)
- CW, 6, column address width (clog2 COLS)
- DW, 8, pixel width
- MEM_LAT, 2, fixed memory read latency in cycles (>=1)
- WM_ROWS, 16, watermark height (used only with WM_TILE_EN)
- WM_COLS, 16, watermark width (used only with WM_TILE_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only when ready=1
- abort  in  1  synchronous abort of the frame in progress
- ready  out  1  idle or done, accepts start
- busy  out  1  frame in progress
- done  out  1  frame complete; held until next start or reset
- im_en  out  1  image memory access strobe
- im_rd_wrn  out  1  1=read, 0=write
- im_row  out  RW  image row address
- im_col  out  CW  image column address
- im_wdata  out  DW  embedded pixel to write
- im_rdata  in  DW  image read data
- wm_en  out  1  watermark memory read strobe
- wm_rd_wrn  out  1  constant 1 (controller only reads the watermark)
- wm_row  out  RW  watermark row address
- wm_col  out  CW  watermark column address
- wm_rdata  in  DW  watermark read data

Behaviour:
- States: IDLE, RD, WAIT, WR, DONE.
- Reset values: state=IDLE, ready=1, busy=0, done=0, im_en=0, wm_en=0, im_rd_wrn=1, wm_rd_wrn=1, all addresses 0, im_wdata=0. Counters and capture registers are also 0.
- IDLE/DONE + start=1 -> RD next cycle. Row and column counters clear to 0 and done clears.
- RD (1 cycle): im_en=1, im_rd_wrn=1, wm_en=1 with the current addresses. Then go to WAIT and load the wait counter with MEM_LAT.
- WAIT (MEM_LAT cycles): read data is valid MEM_LAT cycles after RD. On the edge ending the last WAIT cycle, capture im_rdata into reg_im and wm_rdata into reg_wm. Then go to WR.
- WR (1 cycle): im_en=1, im_rd_wrn=0, same address as RD, im_wdata={reg_im[DW-1:1], reg_wm[DW-1]}. The watermark is binarised by its MSB.
- End of WR: advance col. When col=COLS-1, col wraps to 0 and row increments. When the last pixel (row=ROWS-1, col=COLS-1) is written, go to DONE; otherwise go to RD.
- Cost: MEM_LAT+2 cycles per pixel. done rises exactly ROWS*COLS*(MEM_LAT+2) cycles after the start edge.
- Status flags: busy=1 in RD/WAIT/WR. ready=1 in IDLE/DONE. done=1 only in DONE.
- start while busy is ignored.
- abort=1 in RD/WAIT/WR -> IDLE next cycle. A strobe asserted in the current cycle completes; no further strobes are issued. done stays 0. abort in IDLE/DONE has no effect.
- abort and start in the same cycle while ready: abort wins and the state stays put.
- rst has priority over everything, including mid-frame. No write is issued after reset.
- Outside RD/WR: im_en=wm_en=0 and im_rd_wrn=1. Addresses hold their last value.

Optional Feature:
- Macro: WM_TILE_EN.
- Defined: the watermark address comes from separate wrap counters. wm_col = col mod WM_COLS and wm_row = row mod WM_ROWS, maintained incrementally, with no divider. wm_col restarts at 0 whenever col wraps to 0.
- Undefined: wm_row=im_row and wm_col=im_col; WM_ROWS and WM_COLS are ignored.

Decomposition:
- Package wm_pkg holds the state enum (IDLE, RD, WAIT, WR, DONE), a default DW constant, and the LSB-embed function.
- One sub-module, wm_addr_gen: raster row/col counters plus the optional tile wrap counters. Inputs are clear/advance; outputs are addresses plus last_pixel.

Test Plan:
- Reset: assert rst 2 cycles -> ready=1, busy=0, done=0, im_en=wm_en=0, im_rd_wrn=1.
- Full frame (ROWS=2, COLS=3, MEM_LAT=2), with all im=0x54 and wm=0x80 -> six writes of 0x55 at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), in raster order, 4 cycles apart. done rises 24 cycles after start.
- Embed clear: im=0x55, wm=0x7F -> write 0x54. Write sequence is RD, then 2 WAIT cycles, then WR, with the write at the same address as the read.
- Abort during WAIT of pixel (0,1) -> IDLE next cycle, no write to (0,1), done=0. A following start rescans from (0,0).
- start pulsed while busy -> ignored, frame timing unchanged. start in DONE -> done clears next cycle and a new frame begins.
- WM_TILE_EN, WM_ROWS=1, WM_COLS=2, image 2x3 -> watermark address sequence (0,0),(0,1),(0,0),(0,0),(0,1),(0,0). Without the macro the sequence equals the image addresses.
